icache_refill_ctrl: RTL

Initiator side of the icache memory interface: accepts one line-miss request from the icache, drives a `mem_req_t` request to the memory responder, and captures the returned `mem_rsp_t` line. It then presents the line back to the icache with a valid/ready handshake. It sits between the icache miss logic and the memory model or backing memory, and handles one outstanding refill at a time.

---
 rtl/icache_refill_ctrl.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/icache_refill_ctrl.sv
// -----------------------------------------------------------------------------
// icache_refill_ctrl
//   Initiator side of the icache memory interface. It accepts one line-miss
//   request from the icache and issues a line-aligned request to the memory
//   responder. It captures the returned line and presents it back to the
//   icache with a valid/ready handshake. Only one refill is in flight at a
//   time.
//
//   Optional feature macro: ICACHE_REFILL_TIMEOUT_EN
//     When it is defined, a watchdog abandons a request that has waited
//     TimeoutCycles cycles without a memory handshake and pulses err_o.
//     When it is undefined, the controller waits indefinitely and err_o is
//     tied low.
//
//   Ports
//     clk_i, rst_i       clock, asynchronous active-high reset
//     miss_valid_i/_o    miss handshake from the icache (miss_ready_o out)
//     miss_paddr_i       miss word address
//     kill_i             abort the current refill
//     mreq_o / mrsp_i    memory request / response (mem_req_t / mem_rsp_t)
//     refill_valid_o     line handshake to the icache (refill_ready_i in)
//     refill_paddr_o     line-aligned address of the delivered line
//     refill_data_o      captured line
//     refill_cnt_o       completed refills, wrapping
//     err_o              one-cycle timeout pulse
// -----------------------------------------------------------------------------
package icache_refill_pkg;
  localparam int unsigned ICACHE_LINE_WIDTH = 128;
  localparam int unsigned PADDR_WIDTH       = 32;

  typedef struct packed {
    logic                   req;
    logic [PADDR_WIDTH-1:0] paddr;
  } mem_req_t;

  typedef struct packed {
    logic                         ready;
    logic [ICACHE_LINE_WIDTH-1:0] data;
  } mem_rsp_t;
endpackage

module icache_refill_ctrl
  import icache_refill_pkg::*;
#(
  parameter int unsigned LineWords     = ICACHE_LINE_WIDTH / 32,
  parameter int unsigned TimeoutCycles = 64
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         miss_valid_i,
  output logic                         miss_ready_o,
  input  logic [PADDR_WIDTH-1:0]       miss_paddr_i,
  input  logic                         kill_i,
  output mem_req_t                     mreq_o,
  input  mem_rsp_t                     mrsp_i,
  output logic                         refill_valid_o,
  input  logic                         refill_ready_i,
  output logic [PADDR_WIDTH-1:0]       refill_paddr_o,
  output logic [ICACHE_LINE_WIDTH-1:0] refill_data_o,
  output logic [31:0]                  refill_cnt_o,
  output logic                         err_o
);

  // Clears the word-offset bits so the request always names a whole line.
  localparam logic [PADDR_WIDTH-1:0] LineMask = ~(PADDR_WIDTH'(LineWords - 32'd1));

  // Reject configurations the address masking cannot represent.
  if ((LineWords == 32'd0) || ((LineWords & (LineWords - 32'd1)) != 32'd0) ||
      ((LineWords * 32'd32) > ICACHE_LINE_WIDTH) || (TimeoutCycles == 32'd0)) begin : g_cfg_bad
    $error("icache_refill_ctrl: LineWords must be a power of two fitting the line, TimeoutCycles > 0");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_DELIVER = 2'd2
  } state_e;

  state_e                       state_r;
  state_e                       state_next_s;
  logic [PADDR_WIDTH-1:0]       line_paddr_r;
  logic [ICACHE_LINE_WIDTH-1:0] line_data_r;
  logic [31:0]                  refill_cnt_r;
  logic                         miss_ready_s;
  logic                         req_s;
  logic                         refill_valid_s;
  logic                         accept_s;
  logic                         capture_s;
  logic                         deliver_s;
  logic                         timeout_s;

  // Handshake decodes; kill_i blocks every one of them.
  assign accept_s  = (state_r == ST_IDLE)    && miss_valid_i   && !kill_i;
  assign capture_s = (state_r == ST_REQ)     && mrsp_i.ready   && !kill_i;
  assign deliver_s = (state_r == ST_DELIVER) && refill_ready_i && !kill_i;

`ifdef ICACHE_REFILL_TIMEOUT_EN
  localparam int unsigned         ToWidth = $clog2(TimeoutCycles + 1);
  localparam logic [ToWidth-1:0]  ToLast  = ToWidth'(TimeoutCycles - 32'd1);

  logic [ToWidth-1:0] to_cnt_r;
  logic               err_r;

  // The limit is hit on the cycle whose stall would make the count reach
  // TimeoutCycles; a ready in that same cycle takes priority.
  assign timeout_s = (state_r == ST_REQ) && !mrsp_i.ready && !kill_i && (to_cnt_r == ToLast);

  // Watchdog: cleared when a miss is accepted, counts stalled REQ cycles.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      to_cnt_r <= '0;
    end else if (accept_s) begin
      to_cnt_r <= '0;
    end else if ((state_r == ST_REQ) && !mrsp_i.ready) begin
      to_cnt_r <= to_cnt_r + ToWidth'(1);
    end else begin
      to_cnt_r <= to_cnt_r;
    end
  end

  // Error pulse, registered one cycle after the abandoned request.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_r <= 1'b0;
    end else begin
      err_r <= timeout_s;
    end
  end

  assign err_o = err_r;
`else
  assign timeout_s = 1'b0;
  assign err_o     = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; kill and timeout take precedence over the memory handshake.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_next_s = ST_REQ;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (kill_i || timeout_s) begin
          state_next_s = ST_IDLE;
        end else if (mrsp_i.ready) begin
          state_next_s = ST_DELIVER;
        end else begin
          state_next_s = ST_REQ;
        end
      end
      ST_DELIVER: begin
        if (kill_i || refill_ready_i) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DELIVER;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Output decode from state; miss_ready is withheld during a kill.
  always_comb begin
    miss_ready_s   = 1'b0;
    req_s          = 1'b0;
    refill_valid_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (kill_i) begin
          miss_ready_s = 1'b0;
        end else begin
          miss_ready_s = 1'b1;
        end
      end
      ST_REQ: begin
        req_s = 1'b1;
      end
      ST_DELIVER: begin
        refill_valid_s = 1'b1;
      end
      default: begin
        miss_ready_s   = 1'b0;
        req_s          = 1'b0;
        refill_valid_s = 1'b0;
      end
    endcase
  end

  // Line address latch; serves both the memory request and the delivery.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      line_paddr_r <= '0;
    end else if (accept_s) begin
      line_paddr_r <= miss_paddr_i & LineMask;
    end else begin
      line_paddr_r <= line_paddr_r;
    end
  end

  // Line buffer; a response arriving with kill is dropped.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      line_data_r <= '0;
    end else if (capture_s) begin
      line_data_r <= mrsp_i.data;
    end else begin
      line_data_r <= line_data_r;
    end
  end

  // Completed-refill counter, wrapping naturally at 32 bits.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      refill_cnt_r <= 32'd0;
    end else if (deliver_s) begin
      refill_cnt_r <= refill_cnt_r + 32'd1;
    end else begin
      refill_cnt_r <= refill_cnt_r;
    end
  end

  assign miss_ready_o   = miss_ready_s;
  assign mreq_o         = '{req: req_s, paddr: line_paddr_r};
  assign refill_valid_o = refill_valid_s;
  assign refill_paddr_o = line_paddr_r;
  assign refill_data_o  = line_data_r;
  assign refill_cnt_o   = refill_cnt_r;

endmodule
